// File: rtl/circular_packer.sv
// circular_packer: packs variable-count element beats into full NUM_ELEM-wide words by writing
// each beat at a circularly rotating base equal to the current fill level.
// Latency: a word-completing beat (or a flush of the residue) drives valid_o on the next cycle.
// Backpressure: ready_o = (!valid_o | ready_i) & !flush_pend; data_o/count_o hold while stalled.
// Optional: define CIRCULAR_PACKER_OVERFLOW_FLAG_EN to add the sticky err_o over-range count flag.
module circular_packer #(
  parameter int ELEM_WIDTH = 8,
  parameter int NUM_ELEM   = 6
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [ELEM_WIDTH*NUM_ELEM-1:0]     data_i,
  input  logic [$clog2(NUM_ELEM+1)-1:0]      count_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic                               flush_i,
  output logic [ELEM_WIDTH*NUM_ELEM-1:0]     data_o,
  output logic [$clog2(NUM_ELEM+1)-1:0]      count_o,
  output logic                               valid_o,
  input  logic                               ready_i
`ifdef CIRCULAR_PACKER_OVERFLOW_FLAG_EN
  ,
  output logic                               err_o
`endif
);

  // Count width, a one-bit-wider sum width and the full word width.
  localparam int CW = $clog2(NUM_ELEM + 1);
  localparam int SW = CW + 1;
  localparam int DW = ELEM_WIDTH * NUM_ELEM;

  localparam logic [CW-1:0] N_C = CW'(NUM_ELEM);
  localparam logic [SW-1:0] N_S = SW'(NUM_ELEM);

  // Residue buffer and fill level. Lanes at or above fill_q hold stale data and are never emitted.
  logic [DW-1:0] stage_q, stage_d;
  logic [CW-1:0] fill_q, fill_d;

  // A flush is owed once the output slot frees up.
  logic          flush_pend_q, flush_pend_d;

  // Single registered output slot.
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] count_q, count_d;

  // Handshake and beat bookkeeping.
  logic          slot_free;
  logic          accept;
  logic          word_full;
  logic          flush_req;
  logic [CW-1:0] cnt_clamp;
  logic [SW-1:0] sum_s;

  // Integer views of the fill level and clamped count for lane arithmetic.
  int            fill_int;
  int            cnt_int;
  int            resid_int;
  int            src_int;

  // Rotated beat, completed word, post-beat residue and zero-padded flush word.
  logic [DW-1:0] rot;
  logic [DW-1:0] word;
  logic [DW-1:0] merged;
  logic [CW-1:0] merged_fill;
  logic [DW-1:0] flush_word;

  // The output drains and refills in the same cycle, so ready follows ready_i combinationally.
  assign slot_free = ~valid_q | ready_i;
  assign ready_o   = slot_free & ~flush_pend_q;
  assign accept    = valid_i & ready_o;
  assign flush_req = flush_i | flush_pend_q;

  assign fill_int  = int'(fill_q);
  assign cnt_int   = int'(cnt_clamp);

  // Clamp over-range counts and form the post-beat fill sum (one bit wider to see the carry).
  always_comb begin
    cnt_clamp = (count_i > N_C) ? N_C : count_i;
    sum_s     = {1'b0, fill_q} + {1'b0, cnt_clamp};
    word_full = accept & (sum_s >= N_S);
  end

  // Rotate input lanes so element k lands in lane (fill + k) mod NUM_ELEM; the mod is a
  // compare-and-subtract so non-power-of-two lane counts wrap correctly.
  always_comb begin
    rot     = '0;
    src_int = 0;
    for (int j = 0; j < NUM_ELEM; j++) begin
      if (j >= fill_int) begin
        src_int = j - fill_int;
      end else begin
        src_int = j + NUM_ELEM - fill_int;
      end
      rot[j*ELEM_WIDTH +: ELEM_WIDTH] = data_i[src_int*ELEM_WIDTH +: ELEM_WIDTH];
    end
  end

  // Merge the accepted beat: either extend the residue, or complete a word from the old residue
  // plus the rotated tail and keep the wrapped head as the new residue.
  always_comb begin
    resid_int   = fill_int + cnt_int - NUM_ELEM;
    word        = '0;
    merged      = stage_q;
    merged_fill = fill_q;
    if (accept) begin
      for (int p = 0; p < NUM_ELEM; p++) begin
        if (word_full) begin
          if (p < fill_int) begin
            word[p*ELEM_WIDTH +: ELEM_WIDTH] = stage_q[p*ELEM_WIDTH +: ELEM_WIDTH];
          end else begin
            word[p*ELEM_WIDTH +: ELEM_WIDTH] = rot[p*ELEM_WIDTH +: ELEM_WIDTH];
          end
          if (p < resid_int) begin
            merged[p*ELEM_WIDTH +: ELEM_WIDTH] = rot[p*ELEM_WIDTH +: ELEM_WIDTH];
          end
        end else if ((p >= fill_int) && (p < fill_int + cnt_int)) begin
          merged[p*ELEM_WIDTH +: ELEM_WIDTH] = rot[p*ELEM_WIDTH +: ELEM_WIDTH];
        end
      end
      merged_fill = word_full ? CW'(resid_int) : CW'(fill_int + cnt_int);
    end
  end

  // Short word for a flush: the live residue lanes, unused lanes forced to zero.
  always_comb begin
    flush_word = '0;
    for (int p = 0; p < NUM_ELEM; p++) begin
      if (p < int'(merged_fill)) begin
        flush_word[p*ELEM_WIDTH +: ELEM_WIDTH] = merged[p*ELEM_WIDTH +: ELEM_WIDTH];
      end
    end
  end

  // Next-state selection: a full word wins the slot; a flush emits the residue only when no full
  // word was formed and the slot is free, otherwise it stays pending and blocks new beats.
  always_comb begin
    stage_d      = merged;
    fill_d       = merged_fill;
    flush_pend_d = 1'b0;
    valid_d      = valid_q & ~ready_i;
    data_d       = data_q;
    count_d      = count_q;
    if (word_full) begin
      valid_d      = 1'b1;
      data_d       = word;
      count_d      = N_C;
      flush_pend_d = flush_req & (merged_fill != '0);
    end else if (flush_req && (merged_fill != '0)) begin
      if (slot_free) begin
        valid_d = 1'b1;
        data_d  = flush_word;
        count_d = merged_fill;
        fill_d  = '0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end
  end

  // State registers; reset discards any staged residue and the output word without emitting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q      <= '0;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      count_q      <= '0;
    end else begin
      stage_q      <= stage_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      count_q      <= count_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;

`ifdef CIRCULAR_PACKER_OVERFLOW_FLAG_EN
  logic err_q, err_d;

  // Sticky over-range flag; the data path still clamps, only reset clears it.
  always_comb begin
    err_d = err_q | (accept & (count_i > N_C));
  end

  // Error flag register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_circular_packer.sv
// Self-checking bench for circular_packer (NUM_ELEM=6, ELEM_WIDTH=8).
// A queue-based element model predicts every output cycle; directed literals pin key cases.
// Randomized beats, flushes, backpressure and occasional mid-run resets follow.
module tb_circular_packer;

  localparam int N  = 6;
  localparam int EW = 8;

  logic        clk;
  logic        rst_i;
  logic [47:0] data_i;
  logic [2:0]  count_i;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [47:0] data_o;
  logic [2:0]  count_o;
  logic        valid_o;
  logic        ready_i;
`ifdef CIRCULAR_PACKER_OVERFLOW_FLAG_EN
  logic        err_o;
  logic        merr;
`endif

  int n_vec = 0;
  int n_mis = 0;

  circular_packer #(.ELEM_WIDTH(EW), .NUM_ELEM(N)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .count_i (count_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .flush_i (flush_i),
    .data_o  (data_o),
    .count_o (count_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
`ifdef CIRCULAR_PACKER_OVERFLOW_FLAG_EN
    ,
    .err_o   (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model state: residue as an element queue, one output slot, pending flush.
  logic [7:0]  mq[$];
  logic        mv;
  logic        mfp;
  logic [2:0]  mcount;
  logic [47:0] mdata;
  bit          armed = 0;

  logic        m_slot;
  logic        m_rdy;
  logic        m_freq;
  logic        m_emit;
  int          m_c;

  // Compare DUT against the model on the falling edge, then advance the model with the inputs.
  always @(negedge clk) begin
    if (rst_i) begin
      mq.delete();
      mv     = 1'b0;
      mfp    = 1'b0;
      mcount = '0;
      mdata  = '0;
`ifdef CIRCULAR_PACKER_OVERFLOW_FLAG_EN
      merr   = 1'b0;
`endif
      armed  = 1;
    end else if (armed) begin
      m_slot = !mv || ready_i;
      m_rdy  = m_slot && !mfp;
      chk("model_valid_o", 64'(valid_o), 64'(mv));
      chk("model_ready_o", 64'(ready_o), 64'(m_rdy));
      if (mv) begin
        chk("model_count_o", 64'(count_o), 64'(mcount));
        chk("model_data_o", 64'(data_o), 64'(mdata));
      end
`ifdef CIRCULAR_PACKER_OVERFLOW_FLAG_EN
      chk("model_err_o", 64'(err_o), 64'(merr));
`endif
      m_emit = 1'b0;
      if (valid_i && m_rdy) begin
        m_c = (int'(count_i) > N) ? N : int'(count_i);
`ifdef CIRCULAR_PACKER_OVERFLOW_FLAG_EN
        if (int'(count_i) > N) merr = 1'b1;
`endif
        for (int k = 0; k < m_c; k++) mq.push_back(data_i[k*8 +: 8]);
      end
      m_freq = flush_i || mfp;
      if (mq.size() >= N) begin
        for (int k = 0; k < N; k++) mdata[k*8 +: 8] = mq.pop_front();
        mcount = 3'(N);
        mv     = 1'b1;
        m_emit = 1'b1;
        mfp    = m_freq && (mq.size() > 0);
      end else if (m_freq && (mq.size() > 0) && m_slot) begin
        mdata  = '0;
        mcount = 3'(mq.size());
        for (int k = 0; k < mq.size(); k++) mdata[k*8 +: 8] = mq[k];
        mq.delete();
        mv     = 1'b1;
        m_emit = 1'b1;
        mfp    = 1'b0;
      end else begin
        mfp = m_freq && (mq.size() > 0);
      end
      if (!m_emit) mv = mv && !ready_i;
    end
  end

  task automatic step(input logic v, input logic [2:0] c, input logic [47:0] d,
                      input logic fl, input logic rdy);
    valid_i = v;
    count_i = c;
    data_i  = d;
    flush_i = fl;
    ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0;
    count_i = '0;
    data_i  = '0;
    flush_i = 1'b0;
    ready_i = 1'b1;
  endtask

  logic [47:0] rd;
  logic [2:0]  rc;

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Reset state.
    chk("reset_valid_o", 64'(valid_o), 64'd0);
    chk("reset_data_o", 64'(data_o), 64'd0);
    chk("reset_count_o", 64'(count_o), 64'd0);
    chk("reset_ready_o", 64'(ready_o), 64'd1);

    // Packing: A(4) + B(4) -> A0..A3,B0,B1.
    step(1, 3'd4, 48'h0000_A3A2A1A0, 0, 1);
    chk("pack_no_early_word", 64'(valid_o), 64'd0);
    step(1, 3'd4, 48'h0000_B3B2B1B0, 0, 1);
    chk("pack_valid_o", 64'(valid_o), 64'd1);
    chk("pack_count_o", 64'(count_o), 64'd6);
    chk("pack_data_o", 64'(data_o), 64'h0000_B1B0_A3A2_A1A0);

    // Rotation wrap: f=2 + C(6) -> B2,B3,C0..C3; residue C4,C5 then D, F complete in order.
    step(1, 3'd6, 48'hC5C4_C3C2_C1C0, 0, 1);
    chk("wrap_data_o", 64'(data_o), 64'h0000_C3C2_C1C0_B3B2);
    chk("wrap_count_o", 64'(count_o), 64'd6);
    step(1, 3'd2, 48'hEEEE_EEEE_D1D0, 0, 1);
    chk("wrap_partial_no_word", 64'(valid_o), 64'd0);
    step(1, 3'd2, 48'h5555_5555_F1F0, 0, 1);
    chk("wrap_residue_order", 64'(data_o), 64'h0000_F1F0_D1D0_C5C4);

    // Backpressure: G word held for 3 stalled cycles.
    step(1, 3'd6, 48'h6564_6362_6160, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd0, 48'h0, 0, 0);
      chk("bp_valid_o", 64'(valid_o), 64'd1);
      chk("bp_data_stable", 64'(data_o), 64'h0000_6564_6362_6160);
      chk("bp_ready_o_low", 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    #1;
    chk("bp_ready_same_cycle", 64'(ready_o), 64'd1);

    // Flush: residue E0,E1 emitted as a short zero-padded word; second flush at f=0 is a no-op.
    step(1, 3'd2, 48'h7777_7777_E1E0, 0, 1);
    step(0, 3'd0, 48'h0, 1, 1);
    chk("flush_valid_o", 64'(valid_o), 64'd1);
    chk("flush_count_o", 64'(count_o), 64'd2);
    chk("flush_data_o", 64'(data_o), 64'h0000_0000_0000_E1E0);
    step(0, 3'd0, 48'h0, 1, 1);
    chk("flush_empty_noop", 64'(valid_o), 64'd0);

    // Beat+flush: f=3 with J(5) -> full word, then residue J3,J4 with count 2.
    step(1, 3'd3, 48'h0000_0072_7170, 0, 1);
    step(1, 3'd5, 48'h0094_9392_9190, 1, 1);
    chk("bf_word_count", 64'(count_o), 64'd6);
    chk("bf_word_data", 64'(data_o), 64'h0000_9291_9072_7170);
    chk("bf_ready_low", 64'(ready_o), 64'd0);
    step(0, 3'd0, 48'h0, 0, 1);
    chk("bf_residue_valid", 64'(valid_o), 64'd1);
    chk("bf_residue_count", 64'(count_o), 64'd2);
    chk("bf_residue_data", 64'(data_o), 64'h0000_0000_0000_9493);
    chk("bf_ready_back", 64'(ready_o), 64'd1);

    // Over-range count clamps to a full word.
    step(1, 3'd7, 48'h0A0B_0C0D_0E0F, 0, 1);
    chk("clamp_count_o", 64'(count_o), 64'd6);
    chk("clamp_data_o", 64'(data_o), 64'h0000_0A0B_0C0D_0E0F);
`ifdef CIRCULAR_PACKER_OVERFLOW_FLAG_EN
    chk("err_set", 64'(err_o), 64'd1);
    step(0, 3'd0, 48'h0, 0, 1);
    chk("err_sticky", 64'(err_o), 64'd1);
`endif
    idle_inputs();
    step(0, 3'd0, 48'h0, 0, 1);

    // Randomized traffic with occasional mid-run reset.
    for (int i = 0; i < 4000; i++) begin
      rst_i = ($urandom_range(0, 599) == 0);
      rd = 48'({$urandom(), $urandom()});
      rc = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      step(($urandom_range(0, 3) != 0), rc, rd,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
    end
    rst_i = 1'b0;
    idle_inputs();
    repeat (4) step(0, 3'd0, 48'h0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
